vector_index_encoder: RTL and testbench

Sequential encoder that is the inverse of the cache's 7-to-128 index decoder. It loads a 128-bit line vector, such as valid or dirty bits, and emits the 7-bit index of every set bit, lowest index first, one per valid/ready transfer. Used by the cache flush/writeback path to walk the lines that need service, then signals completion.

---
 rtl/vector_index_encoder_pkg.sv | 40 ++++
 rtl/vector_index_encoder_lsb.sv | 27 ++
 rtl/vector_index_encoder.sv | 134 +++++++++++++
 tb/tb_vector_index_encoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_index_encoder_pkg.sv
// Shared widths and state encoding for the cache line index decoder/encoder pair.
// Also holds the status-flag decode used by the encoder FSM.
package vector_index_encoder_pkg;

    localparam int VEC_W_DEF = 128;
    localparam int IDX_W_DEF = $clog2(VEC_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic load_rdy;
        logic idx_valid;
        logic busy;
        logic done;
    } status_t;

    // Output flags that hold while the FSM sits in state s.
    function automatic status_t status_of(input state_t s);
        status_t st;
        st = '0;
        case (s)
            IDLE: st.load_rdy = 1'b1;
            SCAN: begin
                st.idx_valid = 1'b1;
                st.busy      = 1'b1;
            end
            DONE: begin
                st.busy = 1'b1;
                st.done = 1'b1;
            end
            default: st.load_rdy = 1'b1;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/vector_index_encoder_lsb.sv
// Combinational lowest-set-bit encoder: index of the lowest 1 in vec, plus an any-set flag.
module lsb_encoder
    import vector_index_encoder_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [VEC_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: both outputs get a default before the loop so no path leaves them
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Walking downward lets the lowest set bit make the final assignment.
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_index_encoder.sv
// Sequential line-vector encoder: emits the index of every set bit, lowest first, then pulses done.
// Optional macro VIE_REMAINING_EN adds the 'remaining' population-count output.
module vector_index_encoder
    import vector_index_encoder_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [VEC_W-1:0] vec_in,
    output logic             load_rdy,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_out,
    input  logic             abort,
    output logic             busy,
    output logic             done
`ifdef VIE_REMAINING_EN
    ,
    output logic [IDX_W:0]   remaining
`endif
);

    state_t           state;
    status_t          status;
    logic [VEC_W-1:0] pending;
    logic [VEC_W-1:0] low_mask;
    logic [VEC_W-1:0] pending_after;
    logic [IDX_W-1:0] low_idx;
    logic             low_any;
    logic             xfer;

    lsb_encoder #(
        .VEC_W (VEC_W),
        .IDX_W (IDX_W)
    ) u_lsb (
        .vec (pending),
        .idx (low_idx),
        .any (low_any)
    );

    assign low_mask      = {{(VEC_W-1){1'b0}}, 1'b1} << low_idx;
    assign pending_after = pending & ~low_mask;
    assign xfer          = (state == SCAN) && low_any && idx_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: pending is a plain register, not a memory, and must be cleared
            // so a reset mid-scan drops every outstanding line.
            state   <= IDLE;
            pending <= '0;
            status  <= status_of(IDLE);
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        pending <= vec_in;
                        if (|vec_in) begin
                            state  <= SCAN;
                            status <= status_of(SCAN);
                        end else begin
                            state  <= DONE;
                            status <= status_of(DONE);
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state   <= IDLE;
                        pending <= '0;
                        status  <= status_of(IDLE);
                    end else if (xfer) begin
                        pending <= pending_after;
                        if (pending_after == '0) begin
                            state  <= DONE;
                            status <= status_of(DONE);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    status <= status_of(IDLE);
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                    status  <= status_of(IDLE);
                end
            endcase
        end
    end

    assign load_rdy  = status.load_rdy;
    assign idx_valid = status.idx_valid;
    assign busy      = status.busy;
    assign done      = status.done;
    // Pending is zero outside SCAN, so the encoder reads 0 there.
    assign idx_out   = low_idx;

`ifdef VIE_REMAINING_EN
    function automatic logic [IDX_W:0] popcount(input logic [VEC_W-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < VEC_W; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Tracks popcount(pending) incrementally rather than re-counting every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else begin
            case (state)
                IDLE: if (load) remaining <= popcount(vec_in);
                SCAN: begin
                    if (abort) begin
                        remaining <= '0;
                    end else if (xfer) begin
                        remaining <= remaining - {{IDX_W{1'b0}}, 1'b1};
                    end
                end
                default: remaining <= '0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_vector_index_encoder.sv
// Self-checking bench for vector_index_encoder: directed timing checks plus a
// randomized scoreboard fed from a set-bit list model.
module tb_vector_index_encoder;
    import vector_index_encoder_pkg::*;

    localparam int VW = VEC_W_DEF;
    localparam int IW = IDX_W_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [VW-1:0] vec_in = '0;
    logic          load_rdy;
    logic          idx_valid;
    logic          idx_ready = 1'b0;
    logic [IW-1:0] idx_out;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
`ifdef VIE_REMAINING_EN
    logic [IW:0]   remaining;
`endif

    int tests = 0;
    int fails = 0;
    int exp_q[$];          // expected transfers in order; -1 marks the done pulse
    logic          prev_stall = 1'b0;
    logic [IW-1:0] prev_idx = '0;

    vector_index_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .vec_in    (vec_in),
        .load_rdy  (load_rdy),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx_out   (idx_out),
        .abort     (abort),
        .busy      (busy),
        .done      (done)
`ifdef VIE_REMAINING_EN
        ,
        .remaining (remaining)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits for load_rdy, loads v and, when tracked, queues every set index then done.
    task automatic do_load(input logic [VW-1:0] v, input bit track);
        int budget;
        budget = 0;
        while (load_rdy !== 1'b1 && budget < 1000) begin
            next_cycle();
            budget++;
        end
        if (load_rdy !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL load_wait_timeout: load_rdy=%b after %0d cycles", load_rdy, budget);
        end
        load   = 1'b1;
        vec_in = v;
        if (track) begin
            for (int i = 0; i < VW; i++)
                if (v[i]) exp_q.push_back(i);
            exp_q.push_back(-1);
        end
        next_cycle();
        load   = 1'b0;
        vec_in = '0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    // Monitor: compares every transfer and done pulse against the queue.
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_valid", {31'b0, idx_valid}, 1);
            check("stall_idx", {25'b0, idx_out}, {25'b0, prev_idx});
        end
        if (idx_valid === 1'b1 && idx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_index: got %0d, required no transfer", idx_out);
            end else begin
                check("index_order", {25'b0, idx_out}, exp_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, required done=0");
            end else begin
                check("done_slot", {31'b0, exp_q.pop_front() == -1}, 1);
            end
        end
        if ((abort === 1'b1 && idx_valid === 1'b1) || rst === 1'b1) exp_q.delete();
        prev_stall <= (idx_valid === 1'b1) && (idx_ready !== 1'b1) && (abort !== 1'b1) && (rst !== 1'b1);
        prev_idx   <= idx_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] v;
        int            cycles;

        // Reset state
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_load_rdy", {31'b0, load_rdy}, 1);
        check("rst_idx_valid", {31'b0, idx_valid}, 0);
        check("rst_idx_out", {25'b0, idx_out}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
`ifdef VIE_REMAINING_EN
        check("rst_remaining", {24'b0, remaining}, 0);
`endif
        next_cycle();

        // Single bit 0: index at n+1, done at n+2, ready at n+3
        idx_ready = 1'b1;
        v = '0; v[0] = 1'b1;
        do_load(v, 1);
        @(negedge clk);
        check("t1_valid", {31'b0, idx_valid}, 1);
        check("t1_idx", {25'b0, idx_out}, 0);
        @(negedge clk);
        check("t1_done", {31'b0, done}, 1);
        check("t1_done_valid", {31'b0, idx_valid}, 0);
        @(negedge clk);
        check("t1_load_rdy", {31'b0, load_rdy}, 1);
        check("t1_done_low", {31'b0, done}, 0);
        next_cycle();

        // Bits {0,5,127} back to back
        v = '0; v[0] = 1'b1; v[5] = 1'b1; v[VW-1] = 1'b1;
        do_load(v, 1);
        @(negedge clk); check("t2_idx0", {25'b0, idx_out}, 0);
        @(negedge clk); check("t2_idx5", {25'b0, idx_out}, 5);
        @(negedge clk); check("t2_idx127", {25'b0, idx_out}, VW - 1);
        check("t2_valid127", {31'b0, idx_valid}, 1);
        @(negedge clk); check("t2_done", {31'b0, done}, 1);
        next_cycle();

        // Empty vector: straight to done
        do_load('0, 1);
        @(negedge clk);
        check("t3_done", {31'b0, done}, 1);
        check("t3_valid", {31'b0, idx_valid}, 0);
        check("t3_busy", {31'b0, busy}, 1);
        @(negedge clk);
        check("t3_busy_fall", {31'b0, busy}, 0);
        check("t3_done_fall", {31'b0, done}, 0);
        next_cycle();

        // Backpressure on {3,64}
        idx_ready = 1'b0;
        v = '0; v[3] = 1'b1; v[64] = 1'b1;
        do_load(v, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_hold_idx", {25'b0, idx_out}, 3);
        end
        next_cycle();
        idx_ready = 1'b1;
        @(negedge clk); check("t4_idx3", {25'b0, idx_out}, 3);
        @(negedge clk); check("t4_idx64", {25'b0, idx_out}, 64);
        @(negedge clk); check("t4_done", {31'b0, done}, 1);
        next_cycle();

        // All ones, abort alongside the accept of index 10; a load while busy is ignored
        do_load('1, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_idx", {25'b0, idx_out}, k);
            next_cycle();
            load   = (k == 3);
            vec_in = (k == 3) ? {1'b1, {(VW-1){1'b0}}} : '0;
        end
        abort = 1'b1;
        @(negedge clk);
        check("t5_idx10", {25'b0, idx_out}, 10);
`ifdef VIE_REMAINING_EN
        check("t5_remaining", {24'b0, remaining}, VW - 10);
`endif
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check("t5_idle_rdy", {31'b0, load_rdy}, 1);
        check("t5_idle_valid", {31'b0, idx_valid}, 0);
        check("t5_idle_busy", {31'b0, busy}, 0);
        check("t5_no_done", {31'b0, done}, 0);
`ifdef VIE_REMAINING_EN
        check("t5_remaining_clr", {24'b0, remaining}, 0);
`endif
        next_cycle();

        // Reset in the cycle index 2 is presented
        v = '0; v[7:0] = 8'hFF;
        do_load(v, 1);
        @(negedge clk); check("t6_idx0", {25'b0, idx_out}, 0);
        next_cycle();
        @(negedge clk); check("t6_idx1", {25'b0, idx_out}, 1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk); check("t6_idx2", {25'b0, idx_out}, 2);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", {31'b0, idx_valid}, 0);
        check("t6_busy", {31'b0, busy}, 0);
        check("t6_load_rdy", {31'b0, load_rdy}, 1);
        check("t6_done", {31'b0, done}, 0);
        next_cycle();
        v = '0; v[9] = 1'b1;
        do_load(v, 1);
        @(negedge clk); check("t6_fresh_idx", {25'b0, idx_out}, 9);
        @(negedge clk); check("t6_fresh_done", {31'b0, done}, 1);
        next_cycle();

        // Randomized scans with random backpressure and occasional abort
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: v = '0;
                1: begin v = '0; v[$urandom_range(0, VW-1)] = 1'b1; end
                2, 4: v = rand_vec() & rand_vec() & rand_vec();
                default: v = rand_vec();
            endcase
            idx_ready = ($urandom_range(0, 3) != 0);
            do_load(v, 1);
            cycles = 0;
            forever begin
                @(negedge clk);
                if (load_rdy === 1'b1) break;
                if (cycles > 2000) begin
                    tests++;
                    fails++;
                    $display("FAIL scan_timeout: load_rdy=%b after %0d cycles, required 1", load_rdy, cycles);
                    break;
                end
                next_cycle();
                idx_ready = ($urandom_range(0, 3) != 0);
                abort     = ($urandom_range(0, 59) == 0);
                cycles++;
            end
            abort = 1'b0;
            next_cycle();
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
